tqvp_mac_sequencer: RTL and testbench

//  Job sequencer for the MAC datapath in a TinyQV peripheral slot. The host loads operand pairs

---
 rtl/tqvp_mac_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_tqvp_mac_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_mac_sequencer.sv
// tqvp_mac_sequencer: TinyQV peripheral that buffers operand pairs in a small FIFO
// and streams a programmable number of them into an external MAC unit over a
// valid/ready handshake, then waits for the MAC to drain and raises an interrupt.
module tqvp_mac_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int OP_W       = 16,
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       address,
    input  logic [31:0]      data_in,
    input  logic [1:0]       data_write_n,
    input  logic [1:0]       data_read_n,
    output logic [31:0]      data_out,
    output logic             data_ready,
    output logic             user_interrupt,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_valid,
    input  logic             mac_ready,
    output logic             mac_clear,
    input  logic             mac_idle,
    input  logic [ACC_W-1:0] mac_acc
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] len_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             done_irq_reg;
    logic             overflow_reg;

    // Operand pair storage, {B, A}; the head is read asynchronously so the MAC
    // always sees the current pair without a read-latency bubble.
    logic [2*OP_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;

    logic        wr_any;
    logic        wr_ctrl;
    logic        start_cmd;
    logic        abort_cmd;
    logic        irq_clr_cmd;
    logic        push_req;
    logic        wr_len;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push_ok;
    logic        busy;
    logic [31:0] status_word;
    logic        unused_ok;

    // Register write decode. ABORT overrides START when both arrive together.
    assign wr_any      = (data_write_n != 2'b11);
    assign wr_ctrl     = wr_any && (address == 6'h00);
    assign abort_cmd   = wr_ctrl && data_in[3];
    assign start_cmd   = wr_ctrl && data_in[0] && !data_in[3];
    assign irq_clr_cmd = wr_ctrl && data_in[2];
    assign push_req    = (data_write_n == 2'b10) && (address == 6'h04);
    assign wr_len      = wr_any && (address == 6'h08);

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == LVL_FULL);
    assign busy       = (state_reg != ST_IDLE);

    // A full FIFO still takes a push when the head is leaving in the same cycle.
    assign mac_valid = (state_reg == ST_RUN) && !fifo_empty && (remaining_reg != '0);
    assign pop       = mac_valid && mac_ready;
    assign push_ok   = push_req && (!fifo_full || pop);

    assign mac_a          = fifo_mem[rd_ptr_reg][OP_W-1:0];
    assign mac_b          = fifo_mem[rd_ptr_reg][2*OP_W-1:OP_W];
    assign mac_clear      = (state_reg == ST_CLEAR);
    assign user_interrupt = done_irq_reg;
    assign data_ready     = 1'b1;
    assign unused_ok      = ^data_read_n;

    // FIFO storage write; contents need no reset since the level qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= {data_in[16 +: OP_W], data_in[OP_W-1:0]};
        end
    end

    // FIFO pointers and fill level; ABORT flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (abort_cmd) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push_ok && !pop)      level_reg <= level_reg + LVL_W'(1);
            else if (pop && !push_ok) level_reg <= level_reg - LVL_W'(1);
        end
    end

    // Job length register and sticky overflow flag (a drop beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_len) len_reg <= data_in[CNT_W-1:0];
            if (push_req && fifo_full && !pop) overflow_reg <= 1'b1;
            else if (irq_clr_cmd)              overflow_reg <= 1'b0;
        end
    end

    // Job sequencing FSM with the remaining-pair counter and done interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            done_irq_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_DONE && !abort_cmd) done_irq_reg <= 1'b1;
            else if (irq_clr_cmd)                   done_irq_reg <= 1'b0;

            if (abort_cmd) begin
                state_reg     <= ST_IDLE;
                remaining_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_cmd) begin
                            remaining_reg <= len_reg;
                            state_reg     <= data_in[1] ? ST_CLEAR : ST_RUN;
                        end
                    end
                    ST_CLEAR: state_reg <= ST_RUN;
                    ST_RUN: begin
                        if (remaining_reg == '0) state_reg <= ST_DRAIN;
                        else if (pop)            remaining_reg <= remaining_reg - CNT_W'(1);
                    end
                    ST_DRAIN: if (mac_idle) state_reg <= ST_DONE;
                    ST_DONE:  state_reg <= ST_IDLE;
                    default:  state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_word                  = '0;
        status_word[0]               = busy;
        status_word[1]               = done_irq_reg;
        status_word[2]               = fifo_empty;
        status_word[3]               = fifo_full;
        status_word[4]               = overflow_reg;
        status_word[8 +: LVL_W]      = level_reg;
        status_word[24 +: CNT_W]     = remaining_reg;
    end

    // Combinational read mux; unmapped and write-only addresses read zero.
    always_comb begin
        data_out = '0;
        case (address)
            6'h08:   data_out[CNT_W-1:0] = len_reg;
            6'h0C:   data_out = status_word;
            6'h10:   data_out = 32'(mac_acc);
            default: data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_tqvp_mac_sequencer.sv
// Bench for tqvp_mac_sequencer: a register-bus vector table followed by
// hand-written job sequences; a behavioural MAC and a pair scoreboard sit on
// the MAC handshake.
module tb_tqvp_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_valid;
    logic        mac_ready;
    logic        mac_clear;
    logic        mac_idle;
    logic [31:0] mac_acc;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          model_level = 0;
    int          hs_count = 0;
    int          clear_count = 0;
    int          valid_cycles = 0;
    logic [31:0] acc_model = 32'd0;

    assign mac_acc = acc_model;

    always #5 clk = ~clk;

    tqvp_mac_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt),
        .mac_a          (mac_a),
        .mac_b          (mac_b),
        .mac_valid      (mac_valid),
        .mac_ready      (mac_ready),
        .mac_clear      (mac_clear),
        .mac_idle       (mac_idle),
        .mac_acc        (mac_acc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural MAC plus scoreboard, sampled mid-cycle ahead of the accepting edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_clear) begin
                clear_count++;
                acc_model = 32'd0;
            end
            if (mac_valid) valid_cycles++;
            if (mac_valid && mac_ready) begin
                hs_count++;
                model_level--;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL handshake_unexpected: got pair a=%0d b=%0d, expected none", mac_a, mac_b);
                end else begin
                    check("handshake_pair", {mac_b, mac_a}, exp_q.pop_front());
                end
                acc_model = acc_model + 32'(mac_a) * 32'(mac_b);
                $display("handshake %0d: a=%0d b=%0d", hs_count, mac_a, mac_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] wn);
        address      = addr;
        data_in      = data;
        data_write_n = wn;
        @(posedge clk);
        if (addr == 6'h04 && wn == 2'b10 && model_level < 8) begin
            exp_q.push_back(data);
            model_level++;
        end
        if (addr == 6'h00 && wn != 2'b11 && data[3]) begin
            exp_q.delete();
            model_level = 0;
        end
        #1;
        data_write_n = 2'b11;
    endtask

    task automatic bus_read_check(input string name, input logic [5:0] addr, input logic [31:0] exp);
        address     = addr;
        data_read_n = 2'b10;
        #1;
        check(name, data_out, exp);
        data_read_n = 2'b11;
        tick();
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n = 0;
        while (!user_interrupt && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(user_interrupt), 32'd1);
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(hs_count >= target), 32'd1);
    endtask

    typedef struct {
        logic        is_read;
        logic [1:0]  wn;
        logic [5:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int clr0;
        int v0;
        int n;

        vecs[0]  = '{1'b0, 2'b10, 6'h08, 32'h0000_01AB};
        vecs[1]  = '{1'b1, 2'b11, 6'h08, 32'h0000_00AB};
        vecs[2]  = '{1'b1, 2'b11, 6'h14, 32'h0000_0000};
        vecs[3]  = '{1'b1, 2'b11, 6'h3C, 32'h0000_0000};
        vecs[4]  = '{1'b1, 2'b11, 6'h10, 32'h0000_0000};
        vecs[5]  = '{1'b0, 2'b01, 6'h04, 32'h0002_0001};
        vecs[6]  = '{1'b1, 2'b11, 6'h0C, 32'h0000_0004};
        vecs[7]  = '{1'b0, 2'b00, 6'h04, 32'h0002_0001};
        vecs[8]  = '{1'b1, 2'b11, 6'h0C, 32'h0000_0004};
        vecs[9]  = '{1'b0, 2'b10, 6'h04, 32'h0008_0007};
        vecs[10] = '{1'b1, 2'b11, 6'h0C, 32'h0000_0100};
        vecs[11] = '{1'b0, 2'b10, 6'h04, 32'h000A_0009};
        vecs[12] = '{1'b1, 2'b11, 6'h0C, 32'h0000_0200};
        vecs[13] = '{1'b0, 2'b10, 6'h00, 32'h0000_0008};
        vecs[14] = '{1'b1, 2'b11, 6'h0C, 32'h0000_0004};
        vecs[15] = '{1'b0, 2'b10, 6'h08, 32'h0000_0000};

        rst_n        = 1'b0;
        address      = 6'h0C;
        data_in      = 32'd0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        mac_ready    = 1'b0;
        mac_idle     = 1'b1;
        #2;
        check("reset_data_ready", 32'(data_ready), 32'd1);
        check("reset_mac_valid", 32'(mac_valid), 32'd0);
        check("reset_mac_clear", 32'(mac_clear), 32'd0);
        check("reset_irq", 32'(user_interrupt), 32'd0);
        check("reset_status", data_out, 32'h0000_0004);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        bus_read_check("reset_len", 6'h08, 32'd0);

        // Register-level vectors.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_read) bus_read_check($sformatf("vec%0d_read", i), vecs[i].addr, vecs[i].data);
            else                 bus_write(vecs[i].addr, vecs[i].data, vecs[i].wn);
        end

        // 1: two-pair job with accumulator clear and interrupt.
        bus_write(6'h04, {16'd4, 16'd3}, 2'b10);
        bus_write(6'h04, {16'd6, 16'd5}, 2'b10);
        bus_write(6'h08, 32'd2, 2'b10);
        mac_ready = 1'b1;
        hs0  = hs_count;
        clr0 = clear_count;
        bus_write(6'h00, 32'h3, 2'b10);
        wait_irq("t1_irq", 30);
        check("t1_handshakes", 32'(hs_count - hs0), 32'd2);
        check("t1_clear_pulses", 32'(clear_count - clr0), 32'd1);
        bus_read_check("t1_result", 6'h10, 32'd42);
        bus_read_check("t1_status", 6'h0C, 32'h0000_0006);
        bus_write(6'h00, 32'h4, 2'b10);
        check("t1_irq_cleared", 32'(user_interrupt), 32'd0);

        // 2: FIFO underrun stalls the job until more pairs arrive.
        bus_write(6'h08, 32'd3, 2'b10);
        bus_write(6'h04, {16'd3, 16'd2}, 2'b10);
        hs0 = hs_count;
        bus_write(6'h00, 32'h1, 2'b10);
        wait_hs("t2_first_hs", hs0 + 1, 20);
        repeat (3) tick();
        check("t2_stall_valid", 32'(mac_valid), 32'd0);
        bus_read_check("t2_status_stalled", 6'h0C, 32'h0200_0005);
        bus_write(6'h04, {16'd5, 16'd4}, 2'b10);
        bus_write(6'h04, {16'd7, 16'd6}, 2'b10);
        wait_irq("t2_irq", 30);
        check("t2_handshakes", 32'(hs_count - hs0), 32'd3);
        bus_read_check("t2_status_done", 6'h0C, 32'h0000_0006);
        bus_write(6'h00, 32'h4, 2'b10);

        // 3: fill, overflow, then push and pop in the same cycle while full.
        mac_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(6'h04, {16'(i + 20), 16'(i + 1)}, 2'b10);
        bus_read_check("t3_full", 6'h0C, 32'h0000_0808);
        bus_write(6'h04, 32'hDEAD_BEEF, 2'b10);
        bus_read_check("t3_overflow", 6'h0C, 32'h0000_0818);
        bus_write(6'h08, 32'd8, 2'b10);
        bus_write(6'h00, 32'h1, 2'b10);
        tick();
        check("t3_valid_running", 32'(mac_valid), 32'd1);
        mac_ready = 1'b1;
        bus_write(6'h04, {16'd99, 16'd98}, 2'b10);
        mac_ready = 1'b0;
        bus_read_check("t3_push_pop_full", 6'h0C, 32'h0700_0819);
        bus_write(6'h00, 32'hC, 2'b10);
        bus_read_check("t3_abort_clear", 6'h0C, 32'h0000_0004);

        // 4: back-pressure holds the pair stable, then ABORT.
        bus_write(6'h04, {16'd12, 16'd11}, 2'b10);
        bus_write(6'h04, {16'd14, 16'd13}, 2'b10);
        bus_write(6'h04, {16'd16, 16'd15}, 2'b10);
        bus_write(6'h08, 32'd3, 2'b10);
        mac_ready = 1'b1;
        hs0 = hs_count;
        bus_write(6'h00, 32'h1, 2'b10);
        wait_hs("t4_first_hs", hs0 + 1, 20);
        mac_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_hold_pair%0d", k), {mac_b, mac_a}, {16'd14, 16'd13});
            check($sformatf("t4_hold_valid%0d", k), 32'(mac_valid), 32'd1);
            tick();
        end
        bus_write(6'h00, 32'h8, 2'b10);
        check("t4_abort_valid", 32'(mac_valid), 32'd0);
        bus_read_check("t4_abort_status", 6'h0C, 32'h0000_0004);
        repeat (3) tick();
        check("t4_abort_no_irq", 32'(user_interrupt), 32'd0);
        check("t4_handshakes", 32'(hs_count - hs0), 32'd1);

        // 5: zero-length job waits only for the MAC to go idle.
        mac_idle = 1'b0;
        bus_write(6'h08, 32'd0, 2'b10);
        v0 = valid_cycles;
        bus_write(6'h00, 32'h1, 2'b10);
        repeat (4) tick();
        bus_read_check("t5_draining", 6'h0C, 32'h0000_0005);
        check("t5_no_irq_yet", 32'(user_interrupt), 32'd0);
        mac_idle = 1'b1;
        n = 0;
        while (!user_interrupt && n < 3) begin
            tick();
            n++;
        end
        check("t5_irq_within_3", 32'(user_interrupt), 32'd1);
        check("t5_no_valid", 32'(valid_cycles - v0), 32'd0);
        bus_write(6'h00, 32'h4, 2'b10);

        // 6: asynchronous reset in the middle of a job.
        bus_write(6'h04, {16'd2, 16'd1}, 2'b10);
        bus_write(6'h04, {16'd4, 16'd3}, 2'b10);
        bus_write(6'h08, 32'd2, 2'b10);
        bus_write(6'h00, 32'h1, 2'b10);
        tick();
        check("t6_valid_before_reset", 32'(mac_valid), 32'd1);
        address = 6'h0C;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_in_reset", 32'(mac_valid), 32'd0);
        check("t6_status_in_reset", data_out, 32'h0000_0004);
        exp_q.delete();
        model_level = 0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_write(6'h04, 32'h0002_0001, 2'b01);
        bus_read_check("t6_half_write_ignored", 6'h0C, 32'h0000_0004);
        bus_read_check("t6_len_reset", 6'h08, 32'd0);
        check("t6_irq_reset", 32'(user_interrupt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
